seq_mult5: RTL and testbench

Sequential 5×5 unsigned shift-and-add multiplier. It produces a 10-bit product in five iteration cycles. Each iteration drives one shared 5-bit ripple-carry adder and consumes its sum and carry-out. The block sits directly downstream of the 5-bit adder stage: it sequences operands into the adder and registers what the adder produces. It is the first clocked datapath built on the lab's adder.

---
 rtl/seq_mult5_pkg.sv | 23 ++
 rtl/seq_mult5_add.sv | 28 ++
 rtl/seq_mult5.sv | 88 ++++++++
 tb/tb_seq_mult5.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult5_pkg
// Purpose  : Shared widths and FSM encoding for the 5x5 sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult5_pkg;

  localparam int c_op_w   = 5;
  localparam int c_prod_w = 10;
  localparam int c_iters  = 5;
  localparam int c_cnt_w  = 3;

  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_iters - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mult5_add.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult5_add
// Purpose  : 5-bit ripple-carry adder built from chained full adders, cin = 0.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult5_add
  import seq_mult5_pkg::*;
(
  input  logic [c_op_w-1:0] i_a,
  input  logic [c_op_w-1:0] i_b,
  output logic [c_op_w-1:0] o_sum,
  output logic              o_cout
);

  logic [c_op_w:0] w_c;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < c_op_w; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = w_c[c_op_w];

endmodule
`default_nettype wire

// File: rtl/seq_mult5.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult5
// Purpose  : 5x5 unsigned shift-and-add multiplier, one adder step per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult5
  import seq_mult5_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_start,
  input  logic [c_op_w-1:0]   in_a,
  input  logic [c_op_w-1:0]   in_b,
  output logic                out_busy,
  output logic                out_done,
  output logic [c_prod_w-1:0] out_p
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_op_w-1:0]    r_m;
  logic [c_op_w-1:0]    r_acc;
  logic [c_op_w-1:0]    r_q;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_op_w-1:0]    w_addend;
  logic [c_op_w-1:0]    w_sum;
  logic                 w_carry;

  assign w_addend = r_m & {c_op_w{r_q[0]}};

  seq_mult5_add u_add (
    .i_a    (r_acc),
    .i_b    (w_addend),
    .o_sum  (w_sum),
    .o_cout (w_carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == c_last_cnt) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The carry-out re-enters as the top bit of the right-shifted {c,s,Q}.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m   <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_m   <= in_a;
            r_q   <= in_b;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        ST_CALC: begin
          {r_acc, r_q} <= {w_carry, w_sum, r_q[c_op_w-1:1]};
          r_cnt        <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_busy = (r_state == ST_CALC);
  assign out_done = (r_state == ST_DONE);
  assign out_p    = {r_acc, r_q};

endmodule
`default_nettype wire

// File: tb/tb_seq_mult5.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult5
// Purpose  : Self-checking bench for seq_mult5 against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_start = 1'b0;
  logic [4:0] in_a = '0;
  logic [4:0] in_b = '0;
  logic       out_busy;
  logic       out_done;
  logic [9:0] out_p;

  int checks = 0;
  int errors = 0;

  seq_mult5 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_start (in_start),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_busy (out_busy),
    .out_done (out_done),
    .out_p    (out_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one multiply from IDLE and waits (bounded) for the done pulse;
  // finishes one cycle after done so the block is back in IDLE.
  task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                        output int lat, output logic [9:0] p,
                        output logic busy_e0, output logic done_after);
    in_a = a; in_b = b; in_start = 1'b1;
    tick();
    busy_e0 = out_busy;
    in_start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_done) break;
    end
    p = out_p;
    tick();
    done_after = out_done;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_busy !== 1'b0 || out_done !== 1'b0 || out_p !== 10'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d busy=%b done=%b p=%0d expected 0/0/0", i, out_busy, out_done, out_p);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_busy !== 1'b0 || out_done !== 1'b0 || out_p !== 10'd0) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d busy=%b done=%b p=%0d expected 0/0/0", i, out_busy, out_done, out_p);
      end
    end
  endtask

  task automatic test_basic();
    logic [4:0] av [3] = '{5'd13, 5'd0, 5'd1};
    logic [4:0] bv [3] = '{5'd11, 5'd17, 5'd31};
    int lat; logic [9:0] p; logic b0, da;
    for (int i = 0; i < 3; i++) begin
      run_op(av[i], bv[i], lat, p, b0, da);
      checks++;
      if (lat !== 5 || !b0) begin
        errors++;
        $display("FAIL basic_latency %0dx%0d lat=%0d busy_e0=%b expected 5/1", av[i], bv[i], lat, b0);
      end
      checks++;
      if (p !== 10'(av[i] * bv[i])) begin
        errors++;
        $display("FAIL basic_product %0dx%0d got %0d expected %0d", av[i], bv[i], p, av[i] * bv[i]);
      end
      checks++;
      if (da !== 1'b0) begin
        errors++;
        $display("FAIL basic_done_width done still %b one cycle later, expected 0", da);
      end
    end
  endtask

  task automatic test_max();
    int lat; logic [9:0] p; logic b0, da; int extra_done = 0;
    run_op(5'd31, 5'd31, lat, p, b0, da);
    checks++;
    if (p !== 10'h3C1 || lat !== 5 || da !== 1'b0) begin
      errors++;
      $display("FAIL max_product p=%0d lat=%0d done_after=%b expected 961/5/0", p, lat, da);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      if (out_done) extra_done++;
    end
    checks++;
    if (out_p !== 10'd961 || extra_done != 0) begin
      errors++;
      $display("FAIL max_hold p=%0d extra_done=%0d expected 961/0", out_p, extra_done);
    end
  endtask

  task automatic test_start_while_busy();
    int dones = 0; int lat; logic [9:0] p; logic b0, da;
    in_a = 5'd6; in_b = 5'd7; in_start = 1'b1;
    tick();                          // E0
    in_start = 1'b0; in_a = 5'd2; in_b = 5'd2;
    tick();                          // E1
    in_start = 1'b1;
    tick();                          // E2: start ignored
    in_start = 1'b0;
    for (int i = 0; i < 3; i++) tick();   // E3..E5
    checks++;
    if (out_done !== 1'b1 || out_busy !== 1'b0 || out_p !== 10'd42) begin
      errors++;
      $display("FAIL busy_start_result done=%b busy=%b p=%0d expected 1/0/42", out_done, out_busy, out_p);
    end
    in_start = 1'b1;
    tick();                          // E6: start in DONE ignored
    in_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_done || out_busy) dones++;
      tick();
    end
    checks++;
    if (dones != 0 || out_p !== 10'd42) begin
      errors++;
      $display("FAIL busy_start_ignored activity=%0d p=%0d expected 0/42", dones, out_p);
    end
    run_op(5'd2, 5'd2, lat, p, b0, da);
    checks++;
    if (p !== 10'd4 || lat !== 5) begin
      errors++;
      $display("FAIL busy_start_next p=%0d lat=%0d expected 4/5", p, lat);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0; int lat; logic [9:0] p; logic b0, da;
    in_a = 5'd25; in_b = 5'd19; in_start = 1'b1;
    tick();                          // E0
    in_start = 1'b0;
    tick(); tick();                  // E1, E2
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_busy !== 1'b0 || out_done !== 1'b0 || out_p !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_async busy=%b done=%b p=%0d expected 0/0/0", out_busy, out_done, out_p);
    end
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_done || out_busy || out_p !== 10'd0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet bad_cycles=%0d expected 0", dones);
    end
    run_op(5'd3, 5'd5, lat, p, b0, da);
    checks++;
    if (p !== 10'd15 || lat !== 5) begin
      errors++;
      $display("FAIL reset_mid_next p=%0d lat=%0d expected 15/5", p, lat);
    end
  endtask

  // Model: held start accepts at edge 0, then every 7 edges; each done
  // appears 5 edges after its acceptance with the product of that edge's operands.
  task automatic test_back_to_back();
    logic [4:0] ea [40];
    logic [4:0] eb [40];
    int ndone = 0; int prev = -1;
    for (int e = 0; e < 40; e++) begin
      ea[e] = 5'($urandom_range(0, 31));
      eb[e] = 5'($urandom_range(0, 31));
      in_a = ea[e]; in_b = eb[e]; in_start = 1'b1;
      tick();
      if (out_done) begin
        ndone++;
        checks++;
        if (e < 5 || out_p !== 10'(ea[e-5] * eb[e-5]) || (prev >= 0 && e - prev != 7) || (prev < 0 && e != 5)) begin
          errors++;
          $display("FAIL b2b_done edge=%0d prev=%0d p=%0d expected product %0d", e, prev,
                   out_p, (e >= 5) ? ea[e-5] * eb[e-5] : -1);
        end
        prev = e;
      end
    end
    in_start = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick(); tick();
    checks++;
    if (ndone != 5) begin
      errors++;
      $display("FAIL b2b_count got %0d dones expected 5", ndone);
    end
  endtask

  task automatic test_random();
    int lat; logic [9:0] p; logic b0, da;
    logic [4:0] a, b;
    for (int i = 0; i < 10; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      run_op(a, b, lat, p, b0, da);
      checks++;
      if (p !== 10'(a * b) || lat !== 5 || da !== 1'b0) begin
        errors++;
        $display("FAIL random_op %0dx%0d p=%0d lat=%0d expected %0d/5", a, b, p, lat, a * b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
